padring_cfg_ctrl: RTL and testbench

PADRING_CFG_CTRL -- requirements
Module: padring_cfg_ctrl

---
 rtl/padring_pkg.sv | 35 +++
 rtl/padring_side_regs.sv | 69 ++++++
 rtl/padring_cfg_ctrl.sv | 166 ++++++++++++++++
 tb/tb_padring_cfg_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/padring_pkg.sv
// Shared side encoding, release order and sequencer state type for the pad-ring
// configuration controller.
package padring_pkg;

  localparam logic [1:0] SideNo = 2'd0;
  localparam logic [1:0] SideSo = 2'd1;
  localparam logic [1:0] SideEa = 2'd2;
  localparam logic [1:0] SideWe = 2'd3;

  // Sides are released we -> no -> ea -> so.
  localparam logic [1:0] RelFirst = SideWe;
  localparam logic [1:0] RelLast  = SideSo;

  typedef enum logic [1:0] {
    StSafe,
    StSeq,
    StLive
  } state_e;

  function automatic logic [1:0] next_side(input logic [1:0] side);
    logic [1:0] nxt;
    case (side)
      SideWe:  nxt = SideNo;
      SideNo:  nxt = SideEa;
      SideEa:  nxt = SideSo;
      default: nxt = RelFirst;
    endcase
    return nxt;
  endfunction

  function automatic logic [3:0] side_onehot(input logic [1:0] side);
    return 4'b0001 << side;
  endfunction

endpackage

// File: rtl/padring_side_regs.sv
// One side of the pad ring: shadow configuration per pad plus registered outputs
// that show the shadow once the side is released and safe values otherwise.
module padring_side_regs #(
  parameter int unsigned GPIO = 9,
  parameter int unsigned CFGW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en_i,
  input  logic [3:0]           wr_pad_i,
  input  logic [CFGW-1:0]      wr_cfg_i,
  input  logic                 wr_ie_i,
  input  logic                 wr_oen_i,
  input  logic                 rel_i,
  output logic [GPIO*CFGW-1:0] pad_cfg_o,
  output logic [GPIO-1:0]      pad_ie_o,
  output logic [GPIO-1:0]      pad_oen_o
);

  logic [GPIO*CFGW-1:0] cfg_q, cfg_d;
  logic [GPIO-1:0]      ie_q, ie_d;
  logic [GPIO-1:0]      oen_q, oen_d;
  logic [GPIO*CFGW-1:0] out_cfg_q, out_cfg_d;
  logic [GPIO-1:0]      out_ie_q, out_ie_d;
  logic [GPIO-1:0]      out_oen_q, out_oen_d;

  always_comb begin
    cfg_d = cfg_q;
    ie_d  = ie_q;
    oen_d = oen_q;
    for (int unsigned i = 0; i < GPIO; i++) begin
      if (wr_en_i && (wr_pad_i == 4'(i))) begin
        cfg_d[i*CFGW +: CFGW] = wr_cfg_i;
        ie_d[i]               = wr_ie_i;
        oen_d[i]              = wr_oen_i;
      end
    end
  end

  // Outputs follow the next shadow so a write lands on the pads one edge later.
  always_comb begin
    out_cfg_d = rel_i ? cfg_d : '0;
    out_ie_d  = rel_i ? ie_d  : '0;
    out_oen_d = rel_i ? oen_d : '1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_q     <= '0;
      ie_q      <= '0;
      oen_q     <= '1;
      out_cfg_q <= '0;
      out_ie_q  <= '0;
      out_oen_q <= '1;
    end else begin
      cfg_q     <= cfg_d;
      ie_q      <= ie_d;
      oen_q     <= oen_d;
      out_cfg_q <= out_cfg_d;
      out_ie_q  <= out_ie_d;
      out_oen_q <= out_oen_d;
    end
  end

  assign pad_cfg_o = out_cfg_q;
  assign pad_ie_o  = out_ie_q;
  assign pad_oen_o = out_oen_q;

endmodule

// File: rtl/padring_cfg_ctrl.sv
// Pad-ring configuration controller: shadow writes for all four sides and a
// power-up sequencer that releases the sides one at a time.
module padring_cfg_ctrl
  import padring_pkg::*;
#(
  parameter int unsigned GPIO   = 9,
  parameter int unsigned CFGW   = 8,
  parameter int unsigned SETTLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_side,
  input  logic [3:0]           req_pad,
  input  logic [CFGW-1:0]      req_cfg,
  input  logic                 req_ie,
  input  logic                 req_oen,
  output logic                 busy,
  output logic                 live,
  output logic                 err,
  output logic [GPIO*CFGW-1:0] no_cfg,
  output logic [GPIO*CFGW-1:0] so_cfg,
  output logic [GPIO*CFGW-1:0] ea_cfg,
  output logic [GPIO*CFGW-1:0] we_cfg,
  output logic [GPIO-1:0]      no_ie,
  output logic [GPIO-1:0]      so_ie,
  output logic [GPIO-1:0]      ea_ie,
  output logic [GPIO-1:0]      we_ie,
  output logic [GPIO-1:0]      no_oen,
  output logic [GPIO-1:0]      so_oen,
  output logic [GPIO-1:0]      ea_oen,
  output logic [GPIO-1:0]      we_oen
);

  localparam logic [7:0] SettleLast = 8'(SETTLE - 1);

  state_e     st_q, st_d;
  logic [1:0] side_q, side_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] rel_q, rel_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       live_q, live_d;
  logic       err_q, err_d;

  logic       acc;
  logic       pad_bad;
  logic       wr_ok;

  assign acc     = req_valid && ready_q;
  assign pad_bad = 32'(req_pad) >= GPIO;
  assign wr_ok   = acc && !pad_bad;

  always_comb begin
    st_d   = st_q;
    side_d = side_q;
    cnt_d  = cnt_q;
    unique case (st_q)
      StSafe: begin
        if (enable) begin
          st_d   = StSeq;
          side_d = RelFirst;
          cnt_d  = SettleLast;
        end
      end
      StSeq: begin
        if (!enable) begin
          st_d = StSafe;
        end else if (cnt_q == 8'd0) begin
          if (side_q == RelLast) begin
            st_d = StLive;
          end else begin
            side_d = next_side(side_q);
            cnt_d  = SettleLast;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StLive: begin
        if (!enable) st_d = StSafe;
      end
      default: st_d = StSafe;
    endcase
  end

  // A side is released the edge after it becomes current, and stays released
  // until the sequencer leaves SEQ/LIVE.
  always_comb begin
    unique case (st_d)
      StSeq:   rel_d = (st_q == StSeq) ? (rel_q | side_onehot(side_q)) : 4'b0000;
      StLive:  rel_d = 4'b1111;
      default: rel_d = 4'b0000;
    endcase
    ready_d = (st_d != StSeq);
    busy_d  = (st_d == StSeq);
    live_d  = (st_d == StLive);
    err_d   = acc && pad_bad;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= StSafe;
      side_q  <= 2'd0;
      cnt_q   <= 8'd0;
      rel_q   <= 4'b0000;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      live_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      side_q  <= side_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      live_q  <= live_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign live      = live_q;
  assign err       = err_q;

  logic [GPIO*CFGW-1:0] side_cfg [4];
  logic [GPIO-1:0]      side_ie  [4];
  logic [GPIO-1:0]      side_oen [4];

  for (genvar s = 0; s < 4; s++) begin : g_side
    padring_side_regs #(
      .GPIO (GPIO),
      .CFGW (CFGW)
    ) u_regs (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (wr_ok && (req_side == 2'(s))),
      .wr_pad_i  (req_pad),
      .wr_cfg_i  (req_cfg),
      .wr_ie_i   (req_ie),
      .wr_oen_i  (req_oen),
      .rel_i     (rel_d[s]),
      .pad_cfg_o (side_cfg[s]),
      .pad_ie_o  (side_ie[s]),
      .pad_oen_o (side_oen[s])
    );
  end

  assign no_cfg = side_cfg[SideNo];
  assign so_cfg = side_cfg[SideSo];
  assign ea_cfg = side_cfg[SideEa];
  assign we_cfg = side_cfg[SideWe];
  assign no_ie  = side_ie[SideNo];
  assign so_ie  = side_ie[SideSo];
  assign ea_ie  = side_ie[SideEa];
  assign we_ie  = side_ie[SideWe];
  assign no_oen = side_oen[SideNo];
  assign so_oen = side_oen[SideSo];
  assign ea_oen = side_oen[SideEa];
  assign we_oen = side_oen[SideWe];

endmodule

// File: tb/tb_padring_cfg_ctrl.sv
// Bench for padring_cfg_ctrl: directed tables, sequencing corner cases and a
// randomized run against a cycle-count based reference model.
module tb_padring_cfg_ctrl;

  localparam int unsigned GPIO   = 9;
  localparam int unsigned CFGW   = 8;
  localparam int unsigned SETTLE = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_side;
  logic [3:0]           req_pad;
  logic [CFGW-1:0]      req_cfg;
  logic                 req_ie;
  logic                 req_oen;
  logic                 busy;
  logic                 live;
  logic                 err;
  logic [GPIO*CFGW-1:0] no_cfg, so_cfg, ea_cfg, we_cfg;
  logic [GPIO-1:0]      no_ie, so_ie, ea_ie, we_ie;
  logic [GPIO-1:0]      no_oen, so_oen, ea_oen, we_oen;

  padring_cfg_ctrl #(
    .GPIO   (GPIO),
    .CFGW   (CFGW),
    .SETTLE (SETTLE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_side  (req_side),
    .req_pad   (req_pad),
    .req_cfg   (req_cfg),
    .req_ie    (req_ie),
    .req_oen   (req_oen),
    .busy      (busy),
    .live      (live),
    .err       (err),
    .no_cfg    (no_cfg),
    .so_cfg    (so_cfg),
    .ea_cfg    (ea_cfg),
    .we_cfg    (we_cfg),
    .no_ie     (no_ie),
    .so_ie     (so_ie),
    .ea_ie     (ea_ie),
    .we_ie     (we_ie),
    .no_oen    (no_oen),
    .so_oen    (so_oen),
    .ea_oen    (ea_oen),
    .we_oen    (we_oen)
  );

  always #5 clk = ~clk;

  logic [GPIO*CFGW-1:0] d_cfg [4];
  logic [GPIO-1:0]      d_ie  [4];
  logic [GPIO-1:0]      d_oen [4];
  assign d_cfg[0] = no_cfg;
  assign d_cfg[1] = so_cfg;
  assign d_cfg[2] = ea_cfg;
  assign d_cfg[3] = we_cfg;
  assign d_ie[0]  = no_ie;
  assign d_ie[1]  = so_ie;
  assign d_ie[2]  = ea_ie;
  assign d_ie[3]  = we_ie;
  assign d_oen[0] = no_oen;
  assign d_oen[1] = so_oen;
  assign d_oen[2] = ea_oen;
  assign d_oen[3] = we_oen;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: mode 0=safe 1=seq 2=live, m_t = edges since entering seq.
  int             m_mode;
  int             m_t;
  logic [CFGW-1:0] m_cfg [4][GPIO];
  logic           m_ie  [4][GPIO];
  logic           m_oen [4][GPIO];
  logic           m_err;
  // Position of each side (indexed no, so, ea, we) in the release order.
  localparam int RelPos [4] = '{1, 3, 2, 0};

  function automatic bit m_rel(int s);
    if (m_mode == 2) return 1'b1;
    if (m_mode == 1) return m_t >= 1 + int'(SETTLE) * RelPos[s];
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_t    = 0;
    m_err  = 1'b0;
    for (int s = 0; s < 4; s++) begin
      for (int p = 0; p < int'(GPIO); p++) begin
        m_cfg[s][p] = '0;
        m_ie[s][p]  = 1'b0;
        m_oen[s][p] = 1'b1;
      end
    end
  endtask

  task automatic model_step();
    bit acc;
    acc   = req_valid && (m_mode != 1);
    m_err = acc && (int'(req_pad) >= int'(GPIO));
    if (acc && int'(req_pad) < int'(GPIO)) begin
      m_cfg[req_side][req_pad] = req_cfg;
      m_ie[req_side][req_pad]  = req_ie;
      m_oen[req_side][req_pad] = req_oen;
    end
    case (m_mode)
      0: if (enable) begin m_mode = 1; m_t = 0; end
      1: begin
        if (!enable) m_mode = 0;
        else begin
          m_t++;
          if (m_t == 4 * int'(SETTLE)) m_mode = 2;
        end
      end
      default: if (!enable) m_mode = 0;
    endcase
  endtask

  function automatic void check_all(string tag);
    chk({tag, " busy"}, 128'(busy), 128'(m_mode == 1));
    chk({tag, " live"}, 128'(live), 128'(m_mode == 2));
    chk({tag, " req_ready"}, 128'(req_ready), 128'(m_mode != 1));
    chk({tag, " err"}, 128'(err), 128'(m_err));
    for (int s = 0; s < 4; s++) begin
      logic [GPIO*CFGW-1:0] ec;
      logic [GPIO-1:0]      ei;
      logic [GPIO-1:0]      eo;
      bit r;
      r = m_rel(s);
      for (int p = 0; p < int'(GPIO); p++) begin
        ec[p*CFGW +: CFGW] = r ? m_cfg[s][p] : '0;
        ei[p] = r && m_ie[s][p];
        eo[p] = r ? m_oen[s][p] : 1'b1;
      end
      chk($sformatf("%s side%0d cfg", tag, s), 128'(d_cfg[s]), 128'(ec));
      chk($sformatf("%s side%0d ie", tag, s), 128'(d_ie[s]), 128'(ei));
      chk($sformatf("%s side%0d oen", tag, s), 128'(d_oen[s]), 128'(eo));
    end
  endfunction

  task automatic drive(input logic en, input logic v, input logic [1:0] side,
                       input logic [3:0] pad, input logic [7:0] cfg, input logic ie,
                       input logic oen);
    enable    = en;
    req_valid = v;
    req_side  = side;
    req_pad   = pad;
    req_cfg   = cfg;
    req_ie    = ie;
    req_oen   = oen;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  int seq_rel [4];
  int seq_live;
  int seq_busy;

  // Holds enable high from SAFE and records when each side first shows
  // non-safe oen, when live rises and how many cycles busy is high.
  task automatic run_seq();
    drive(1'b1, 1'b0, 2'd0, 4'd0, 8'h00, 1'b0, 1'b1);
    for (int s = 0; s < 4; s++) seq_rel[s] = -1;
    seq_live = -1;
    seq_busy = 0;
    for (int k = 0; k < 80; k++) begin
      cycle("seq");
      for (int s = 0; s < 4; s++)
        if (seq_rel[s] < 0 && d_oen[s] != '1) seq_rel[s] = k;
      if (busy) seq_busy++;
      if (live && seq_live < 0) seq_live = k;
    end
  endtask

  typedef struct {
    logic [1:0] side;
    logic [3:0] pad;
    logic [7:0] cfg;
    logic       ie;
    logic       oen;
    logic       exp_err;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t safe_tab [5];
  vec_t live_tab [5];

  task automatic apply_tab(input vec_t v, input string tag);
    logic [GPIO*CFGW-1:0] row;
    int p;
    drive(enable, 1'b1, v.side, v.pad, v.cfg, v.ie, v.oen);
    cycle(tag);
    chk({tag, " err pulse"}, 128'(err), 128'(v.exp_err));
    p = int'(v.pad);
    if (p < int'(GPIO)) begin
      row = d_cfg[v.side];
      chk({tag, " pad byte"}, 128'(row[p*CFGW +: CFGW]), 128'(v.exp_byte));
    end
    drive(enable, 1'b0, 2'd0, 4'd0, 8'h00, 1'b0, 1'b1);
    cycle(tag);
    chk({tag, " err cleared"}, 128'(err), 128'(0));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    safe_tab[0] = '{2'd1, 4'd2, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00};
    safe_tab[1] = '{2'd3, 4'd0, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00};
    safe_tab[2] = '{2'd0, 4'd0, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00};
    safe_tab[3] = '{2'd2, 4'd0, 8'h33, 1'b1, 1'b0, 1'b0, 8'h00};
    safe_tab[4] = '{2'd2, 4'd9, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h00};
    live_tab[0] = '{2'd3, 4'd8, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C};
    live_tab[1] = '{2'd3, 4'd9, 8'h55, 1'b0, 1'b0, 1'b1, 8'h00};
    live_tab[2] = '{2'd0, 4'd4, 8'hC3, 1'b1, 1'b0, 1'b0, 8'hC3};
    live_tab[3] = '{2'd1, 4'd15, 8'h77, 1'b1, 1'b0, 1'b1, 8'h00};
    live_tab[4] = '{2'd2, 4'd8, 8'h81, 1'b0, 1'b1, 1'b0, 8'h81};

    reset = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 4'd0, 8'h00, 1'b0, 1'b1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("reset");
    chk("reset so_oen", 128'(so_oen), 128'(9'h1FF));

    // Writes in SAFE only reach the shadow.
    for (int i = 0; i < 5; i++) apply_tab(safe_tab[i], $sformatf("safe_tab%0d", i));
    chk("safe so_cfg pad2", 128'(so_cfg[23:16]), 128'(8'h00));
    chk("safe so_oen", 128'(so_oen), 128'(9'h1FF));
    chk("safe req_ready", 128'(req_ready), 128'(1));

    run_seq();
    chk("seq we release", 128'(seq_rel[3]), 128'(1));
    chk("seq no release", 128'(seq_rel[0]), 128'(17));
    chk("seq ea release", 128'(seq_rel[2]), 128'(33));
    chk("seq so release", 128'(seq_rel[1]), 128'(49));
    chk("seq live at", 128'(seq_live), 128'(64));
    chk("seq busy cycles", 128'(seq_busy), 128'(64));
    chk("live so_cfg pad2", 128'(so_cfg[23:16]), 128'(8'hA5));

    for (int i = 0; i < 5; i++) apply_tab(live_tab[i], $sformatf("live_tab%0d", i));

    // Back-to-back writes to one pad: one per cycle, last wins.
    drive(1'b1, 1'b1, 2'd0, 4'd1, 8'h11, 1'b1, 1'b0);
    cycle("b2b first");
    chk("b2b first byte", 128'(no_cfg[15:8]), 128'(8'h11));
    drive(1'b1, 1'b1, 2'd0, 4'd1, 8'h22, 1'b0, 1'b1);
    cycle("b2b second");
    drive(1'b1, 1'b0, 2'd0, 4'd0, 8'h00, 1'b0, 1'b1);
    cycle("b2b idle");
    chk("b2b last wins", 128'(no_cfg[15:8]), 128'(8'h22));

    // Abort sequencing at cycle 20, then restart from we.
    drive(1'b0, 1'b0, 2'd0, 4'd0, 8'h00, 1'b0, 1'b1);
    cycle("to safe");
    drive(1'b1, 1'b0, 2'd0, 4'd0, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) cycle("seq pre-abort");
    drive(1'b0, 1'b0, 2'd0, 4'd0, 8'h00, 1'b0, 1'b1);
    cycle("abort");
    chk("abort busy", 128'(busy), 128'(0));
    chk("abort we_oen", 128'(we_oen), 128'(9'h1FF));
    chk("abort no_oen", 128'(no_oen), 128'(9'h1FF));
    run_seq();
    chk("restart we release", 128'(seq_rel[3]), 128'(1));
    chk("restart so release", 128'(seq_rel[1]), 128'(49));
    chk("restart live at", 128'(seq_live), 128'(64));
    chk("restart busy cycles", 128'(seq_busy), 128'(64));

    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 9) < 7),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 10)), 8'($urandom),
            1'($urandom), 1'($urandom));
      cycle("rand");
    end

    drive(1'b1, 1'b0, 2'd0, 4'd0, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 150 && m_mode != 2; k++) cycle("to live");
    chk("pre-reset live", 128'(live), 128'(1));

    // Asynchronous reset mid-cycle while LIVE.
    #2;
    reset = 1'b1;
    #1;
    chk("async reset live", 128'(live), 128'(0));
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("async reset side%0d oen", s), 128'(d_oen[s]), 128'(9'h1FF));
      chk($sformatf("async reset side%0d cfg", s), 128'(d_cfg[s]), 128'(0));
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("post reset");
    run_seq();
    chk("post reset live at", 128'(seq_live), 128'(64));
    for (int s = 0; s < 4; s++)
      chk($sformatf("post reset side%0d shadow cfg", s), 128'(d_cfg[s]), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
